// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame states, legal prescale
// values and the default frame width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int PRESC_8    = 8;
    localparam int PRESC_16   = 16;
    localparam int PRESC_32   = 32;

endpackage

// File: rtl/uart_rx_edge_cnt.sv
// Oversampling edge counter and bit counter for the UART receiver. It emits a
// bit-end strobe on the last edge of every bit.
module uart_rx_edge_cnt
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    input  logic               bit_clr,
    input  logic               bit_inc,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               bit_end
);

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;

    assign bit_end  = run && (edge_cnt_q == (presc - PRESC_W'(1)));
    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

    // Next-count logic; the edge counter parks at 0 while no frame is running
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!run || bit_end) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + PRESC_W'(1);
        end
        if (bit_clr) begin
            bit_cnt_d = '0;
        end else if (bit_inc) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit sequencing, parity and
// stop checks. Optional break detection is enabled with UART_RX_BREAK_DET_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               par_en,
    input  logic               par_typ,
    input  logic               sampled_bit,
    output logic               dat_samp_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic               deser_en,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic               brk_det,
`endif
    output logic               busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    rx_state_e          state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d, presc_legal_s;
    logic               par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic               acc_q, acc_d, err_q, err_d;
    logic               dat_samp_en_q, dat_samp_en_d, busy_q, busy_d;
    logic               deser_en_q, deser_en_d, data_valid_q, data_valid_d;
    logic               par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic               start_s, bit_end_s, bit_clr_s, bit_inc_s, run_s;
    logic               brk_hit_s, brk_block_s;
    logic [BIT_W-1:0]   bit_cnt_s;

    assign run_s = (state_q != IDLE);

    uart_rx_edge_cnt #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BIT_W)
    ) u_edge_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run_s),
        .presc    (presc_q),
        .bit_clr  (bit_clr_s),
        .bit_inc  (bit_inc_s),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt_s),
        .bit_end  (bit_end_s)
    );

    // Anything other than 8/16/32 oversampling falls back to 8
    always_comb begin
        case (prescale)
            PRESC_W'(PRESC_8), PRESC_W'(PRESC_16), PRESC_W'(PRESC_32): presc_legal_s = prescale;
            default: presc_legal_s = PRESC_W'(PRESC_8);
        endcase
    end

    // Frame FSM: next state, pulse generation and per-frame configuration latch
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        acc_d        = acc_q;
        err_d        = err_q;
        deser_en_d   = 1'b0;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        bit_clr_s    = 1'b0;
        bit_inc_s    = 1'b0;
        start_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_in && !brk_block_s) begin
                    start_s = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    if (sampled_bit) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_clr_s = 1'b1;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    deser_en_d = 1'b1;
                    acc_d      = acc_q ^ sampled_bit;
                    bit_inc_s  = 1'b1;
                    if (bit_cnt_s == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    if (sampled_bit != (acc_q ^ par_typ_q)) begin
                        par_err_d = 1'b1;
                        err_d     = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (brk_hit_s) begin
                        state_d = IDLE;
                    end else begin
                        stp_err_d    = ~sampled_bit;
                        data_valid_d = sampled_bit & ~err_q;
                        // A low line at stop end is the next frame's start bit
                        if (!rx_in) begin
                            start_s = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_s) begin
            presc_d   = presc_legal_s;
            par_en_d  = par_en;
            par_typ_d = par_typ;
            acc_d     = 1'b0;
            err_d     = 1'b0;
        end else begin
            presc_d = presc_d;
        end
        dat_samp_en_d = (state_d != IDLE);
        busy_d        = (state_d != IDLE);
    end

`ifdef UART_RX_BREAK_DET_EN
    logic brk_zero_q, brk_zero_d, brk_wait_q, brk_wait_d, brk_det_q, brk_det_d;

    assign brk_hit_s   = (state_q == STOP) && bit_end_s && !sampled_bit && brk_zero_q;
    assign brk_block_s = brk_wait_q;
    assign brk_det     = brk_det_q;

    // Track an all-zero frame and hold off start detection until the line idles
    always_comb begin
        brk_zero_d = brk_zero_q;
        brk_wait_d = brk_wait_q;
        brk_det_d  = 1'b0;
        if (start_s) begin
            brk_zero_d = 1'b1;
        end else if (bit_end_s && ((state_q == DATA) || (state_q == PARITY))) begin
            brk_zero_d = brk_zero_q & ~sampled_bit;
        end else begin
            brk_zero_d = brk_zero_q;
        end
        if (brk_hit_s) begin
            brk_det_d  = 1'b1;
            brk_wait_d = 1'b1;
        end else if (brk_wait_q && rx_in) begin
            brk_wait_d = 1'b0;
        end else begin
            brk_wait_d = brk_wait_q;
        end
    end

    // Break detection registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_zero_q <= 1'b0;
            brk_wait_q <= 1'b0;
            brk_det_q  <= 1'b0;
        end else begin
            brk_zero_q <= brk_zero_d;
            brk_wait_q <= brk_wait_d;
            brk_det_q  <= brk_det_d;
        end
    end
`else
    assign brk_hit_s   = 1'b0;
    assign brk_block_s = 1'b0;
`endif

    // State, latched configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            presc_q       <= PRESC_W'(PRESC_8);
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            acc_q         <= 1'b0;
            err_q         <= 1'b0;
            dat_samp_en_q <= 1'b0;
            busy_q        <= 1'b0;
            deser_en_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            acc_q         <= acc_d;
            err_q         <= err_d;
            dat_samp_en_q <= dat_samp_en_d;
            busy_q        <= busy_d;
            deser_en_q    <= deser_en_d;
            data_valid_q  <= data_valid_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
        end
    end

    assign dat_samp_en = dat_samp_en_q;
    assign busy        = busy_q;
    assign deser_en    = deser_en_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frame-level reference model, a stand-in
// shift-right deserializer and a pulse monitor.
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n, rx_in, par_en, par_typ, sampled_bit;
    logic [5:0] prescale;
    logic       dat_samp_en, deser_en, data_valid, par_err, stp_err, busy;
    logic [5:0] edge_cnt;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk_det;
    localparam bit BRK_ON = 1'b1;
`else
    localparam bit BRK_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .deser_en    (deser_en),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
`ifdef UART_RX_BREAK_DET_EN
        .brk_det     (brk_det),
`endif
        .busy        (busy)
    );

    typedef struct {
        int         kind;   // 0 valid, 1 parity error, 2 stop error, 3 break
        logic [7:0] data;
        int         when;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         deser_cnt = 0;
    int         exp_deser = 0;
    logic [7:0] pdata;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the shift-right deserializer (LSB first)
    always @(posedge clk) if (deser_en) pdata <= {sampled_bit, pdata[7:1]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic got(input int k);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_pulse: got kind %0d at cycle %0d, expected none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            check("pulse_kind", k, e.kind);
            check("pulse_cycle", cyc, e.when);
            if (k == 0) check("p_data", {24'd0, pdata}, {24'd0, e.data});
        end
    endtask

    // Monitor: every output pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (deser_en)   deser_cnt++;
            if (data_valid) got(0);
            if (par_err)    got(1);
            if (stp_err)    got(2);
`ifdef UART_RX_BREAK_DET_EN
            if (brk_det)    got(3);
`endif
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_in = 1'b1;
            if (i >= 2) sampled_bit = 1'b1;
        end
    endtask

    // Sends one frame; sampled_bit follows the line from mid-bit, like the real sampler.
    // abort_bit >= 0 pulls rst_n low in the middle of that frame bit.
    task automatic send_frame(input logic [5:0] pcfg, input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic pbad, input logic sbit,
                              input int abort_bit);
        int   p, nb, nfall;
        logic pbit, perr;
        logic bits [12];
        p    = (pcfg == 6'd8 || pcfg == 6'd16 || pcfg == 6'd32) ? int'(pcfg) : 8;
        pbit = (^d) ^ ptyp ^ pbad;
        perr = pen & pbad;
        bits[0] = 1'b0;
        for (int j = 0; j < DW; j++) bits[j+1] = d[j];
        nb = DW + 1;
        if (pen) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = sbit;
        nb++;
        @(negedge clk);
        nfall    = cyc;
        prescale = pcfg;
        par_en   = pen;
        par_typ  = ptyp;
        if (abort_bit < 0) begin
            exp_deser += DW;
            if (perr) exp_q.push_back('{1, d, nfall + (DW + 2) * p + 1});
            if (!sbit) begin
                if (BRK_ON && d == 8'd0 && (!pen || !pbit))
                    exp_q.push_back('{3, d, nfall + (DW + 2 + int'(pen)) * p + 1});
                else
                    exp_q.push_back('{2, d, nfall + (DW + 2 + int'(pen)) * p + 1});
            end else if (!perr) begin
                exp_q.push_back('{0, d, nfall + (DW + 2 + int'(pen)) * p + 1});
            end
        end else begin
            exp_deser += abort_bit - 1;
        end
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < p; i++) begin
                if (k != 0 || i != 0) @(negedge clk);
                rx_in = bits[k];
                if (i == p / 2 + 2) sampled_bit = bits[k];
                if (k == 0 && i == 1) begin
                    prescale = 6'($urandom);
                    par_en   = 1'($urandom);
                    par_typ  = 1'($urandom);
                end
                if (k == abort_bit && i == p / 2) begin
                    rst_n = 1'b0;
                    #1;
                    check("reset_outputs_midframe",
                          {20'd0, dat_samp_en, edge_cnt, deser_en, data_valid, par_err, stp_err, busy}, 32'd0);
                    @(negedge clk);
                    rst_n       = 1'b1;
                    rx_in       = 1'b1;
                    sampled_bit = 1'b1;
                    return;
                end
            end
        end
    endtask

    logic [5:0] ptab [5];
    logic       sb, pb, gp;

    initial begin
        ptab[0] = 6'd8; ptab[1] = 6'd16; ptab[2] = 6'd32; ptab[3] = 6'd12; ptab[4] = 6'd40;
        rst_n = 1'b0; rx_in = 1'b1; sampled_bit = 1'b1;
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state",
              {20'd0, dat_samp_en, edge_cnt, deser_en, data_valid, par_err, stp_err, busy}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // 1: P=8, no parity, 0xA5
        send_frame(6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(6);
        check("deser_count_t1", deser_cnt, exp_deser);

        // 2: P=16 even parity, good then bad parity bit
        send_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        send_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(6);

        // 3: 3-cycle low glitch at P=16
        @(negedge clk);
        prescale = 6'd16;
        rx_in    = 1'b0;
        @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        idle(20);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("deser_count_t3", deser_cnt, exp_deser);

        // 4: P=32 bad stop bit, then an all-zero break frame
        send_frame(6'd32, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(6);
        send_frame(6'd32, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(6);

        // 5: back-to-back 0x55, 0xFF at P=8
        send_frame(6'd8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(6'd8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(6);
        check("deser_count_t5", deser_cnt, exp_deser);

        // 6: reset during data bit 4, then a clean 0x81
        send_frame(6'd8, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        idle(5);
        send_frame(6'd8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(6);

        // Random frames, including illegal prescale values and back-to-back runs
        for (int n = 0; n < 30; n++) begin
            sb = ($urandom_range(0, 4) != 0);
            pb = ($urandom_range(0, 3) == 0);
            gp = ($urandom_range(0, 1) == 1) || !sb;
            send_frame(ptab[$urandom_range(0, 4)], 8'($urandom), 1'($urandom), 1'($urandom), pb, sb, -1);
            if (gp) idle($urandom_range(3, 12));
        end
        idle(8);
        check("deser_count_total", deser_cnt, exp_deser);
        check("pending_expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
